// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bus_pkg
//  Purpose  : Shared types and constants for the 9-bit CPU memory bus target.
//  Revision : 1.0 - initial release
// ============================================================================
package bus_pkg;

  // Bus transaction FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    GRANT  = 2'd2
  } bus_state_t;

  // Per-core direction encoding
  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  // GPIO window offsets (address[8] = 1)
  localparam logic [7:0] GPIO_OUT_OFS = 8'h00;
  localparam logic [7:0] GPIO_IN_OFS  = 8'h01;

  // RAM geometry
  localparam int RAM_DEPTH = 256;

endpackage : bus_pkg
`default_nettype wire

// File: rtl/bus_ram.sv
`default_nettype none
// ============================================================================
//  Module   : bus_ram
//  Purpose  : 256x8 RAM, synchronous read/write bus port plus a write-only
//             program-load port. The bus port wins a same-address collision.
//  Revision : 1.0 - initial release
// ============================================================================
module bus_ram
  import bus_pkg::*;
(
  input  logic       clk,
  input  logic       bus_we_i,
  input  logic       bus_re_i,
  input  logic [7:0] bus_addr_i,
  input  logic [7:0] bus_wdata_i,
  output logic [7:0] bus_rdata_o,
  input  logic       prog_we_i,
  input  logic [7:0] prog_addr_i,
  input  logic [7:0] prog_data_i
);

  // Contents are deliberately not reset; only the read register matters
  logic [7:0] mem_q [RAM_DEPTH];
  logic [7:0] rdata_q;

  logic w_prog_blocked;
  assign w_prog_blocked = bus_we_i && (bus_addr_i == prog_addr_i);

  // Both write ports commit on the same edge; the program write yields on a collision
  always_ff @(posedge clk) begin
    if (prog_we_i && !w_prog_blocked) begin
      mem_q[prog_addr_i] <= prog_data_i;
    end
    if (bus_we_i) begin
      mem_q[bus_addr_i] <= bus_wdata_i;
    end
    if (bus_re_i) begin
      rdata_q <= mem_q[bus_addr_i];
    end
  end

  assign bus_rdata_o = rdata_q;

endmodule : bus_ram
`default_nettype wire

// File: rtl/bus_responder.sv
`default_nettype none
// ============================================================================
//  Module   : bus_responder
//  Purpose  : Round-robin bus target serving core accesses from a 256-byte
//             RAM or a small GPIO window, with a program-load side port.
//  Revision : 1.0 - initial release
// ============================================================================
module bus_responder
  import bus_pkg::*;
#(
  parameter int NUM_CORES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_CORES-1:0]   grant_request,
  input  logic [NUM_CORES-1:0]   rw,
  input  logic [NUM_CORES*9-1:0] address,
  input  logic [NUM_CORES*8-1:0] wdata,
  output logic [NUM_CORES-1:0]   grant_given,
  output logic [7:0]             rdata,
  input  logic [7:0]             gpio_in,
  output logic [7:0]             gpio_out,
  input  logic                   prog_we,
  input  logic [7:0]             prog_addr,
  input  logic [7:0]             prog_data
);

  localparam int IDXW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  bus_state_t      state_q, state_d;
  logic [IDXW-1:0] winner_q, last_q, sel_d;
  logic            any_req;
  logic            rw_q;
  logic [8:0]      addr_q;
  logic [7:0]      wdata_q;
  logic [7:0]      rdata_q;
  logic            rd_ram_q;
  logic [7:0]      gpio_out_q;
  logic [7:0]      gpio_sync1_q, gpio_sync2_q;

  logic [8:0]      addr_arr  [NUM_CORES];
  logic [7:0]      wdata_arr [NUM_CORES];

  logic            go_access;
  logic            ram_we, ram_re;
  logic [7:0]      ram_rdata;
  logic [7:0]      gpio_rdata;

  // Split the flat per-core buses into indexable arrays
  for (genvar g = 0; g < NUM_CORES; g++) begin : g_unpack
    assign addr_arr[g]  = address[g*9 +: 9];
    assign wdata_arr[g] = wdata[g*8 +: 8];
  end

  // The access commits only if the winner is still requesting at the end of ACCESS
  assign go_access = (state_q == ACCESS) && grant_request[winner_q];
  assign ram_we    = go_access && !addr_q[8] && (rw_q == RW_WRITE);
  assign ram_re    = go_access && !addr_q[8] && (rw_q == RW_READ);

  // Round-robin pick: scan from last+1; descending loop so the nearest requester wins
  always_comb begin
    logic [IDXW-1:0] cand;
    cand    = '0;
    sel_d   = last_q;
    any_req = |grant_request;
    for (int i = NUM_CORES; i >= 1; i--) begin
      cand = IDXW'((int'(last_q) + i) % NUM_CORES);
      if (grant_request[cand]) begin
        sel_d = cand;
      end
    end
  end

  // GPIO read mux for the latched offset
  always_comb begin
    gpio_rdata = 8'h00;
    case (addr_q[7:0])
      GPIO_OUT_OFS: gpio_rdata = gpio_out_q;
      GPIO_IN_OFS:  gpio_rdata = gpio_sync2_q;
      default:      gpio_rdata = 8'h00;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; a dropped request in ACCESS aborts back to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = any_req ? ACCESS : IDLE;
      ACCESS:  state_d = grant_request[winner_q] ? GRANT : IDLE;
      GRANT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: one-hot completion strobe while in GRANT
  always_comb begin
    grant_given = '0;
    if (state_q == GRANT) begin
      grant_given[winner_q] = 1'b1;
    end
  end

  // Transaction capture in IDLE and round-robin pointer update in GRANT
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      winner_q <= '0;
      last_q   <= IDXW'(NUM_CORES - 1);
      rw_q     <= RW_READ;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      if ((state_q == IDLE) && any_req) begin
        winner_q <= sel_d;
        rw_q     <= rw[sel_d];
        addr_q   <= addr_arr[sel_d];
        wdata_q  <= wdata_arr[sel_d];
      end
      if (state_q == GRANT) begin
        last_q <= winner_q;
      end
    end
  end

  // GPIO output register and two-flop input synchroniser
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gpio_out_q   <= 8'h00;
      gpio_sync1_q <= 8'h00;
      gpio_sync2_q <= 8'h00;
    end else begin
      gpio_sync1_q <= gpio_in;
      gpio_sync2_q <= gpio_sync1_q;
      if (go_access && addr_q[8] && (rw_q == RW_WRITE) && (addr_q[7:0] == GPIO_OUT_OFS)) begin
        gpio_out_q <= wdata_q;
      end
    end
  end

  // Read-data holding register; RAM reads land one edge later, so fold them in during GRANT
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q  <= 8'h00;
      rd_ram_q <= 1'b0;
    end else begin
      if (go_access) begin
        rd_ram_q <= ram_re;
        if (rw_q == RW_WRITE) begin
          rdata_q <= 8'h00;
        end else if (addr_q[8]) begin
          rdata_q <= gpio_rdata;
        end
      end
      if ((state_q == GRANT) && rd_ram_q) begin
        rdata_q <= ram_rdata;
      end
    end
  end

  assign rdata    = ((state_q == GRANT) && rd_ram_q) ? ram_rdata : rdata_q;
  assign gpio_out = gpio_out_q;

  bus_ram u_ram (
    .clk         (clk),
    .bus_we_i    (ram_we),
    .bus_re_i    (ram_re),
    .bus_addr_i  (addr_q[7:0]),
    .bus_wdata_i (wdata_q),
    .bus_rdata_o (ram_rdata),
    .prog_we_i   (prog_we),
    .prog_addr_i (prog_addr),
    .prog_data_i (prog_data)
  );

endmodule : bus_responder
`default_nettype wire

// File: tb/tb_bus_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bus_responder
//  Purpose  : Directed, table-driven self-checking bench for bus_responder.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bus_responder;

  localparam int N = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N-1:0]   rwv;
  logic [N*9-1:0] addr;
  logic [N*8-1:0] wd;
  logic [N-1:0]   gg;
  logic [7:0]     rdata;
  logic [7:0]     gpio_in;
  logic [7:0]     gpio_out;
  logic           prog_we;
  logic [7:0]     prog_addr;
  logic [7:0]     prog_data;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  bus_responder #(.NUM_CORES(N)) dut (
    .clk           (clk),
    .reset         (reset),
    .grant_request (req),
    .rw            (rwv),
    .address       (addr),
    .wdata         (wd),
    .grant_given   (gg),
    .rdata         (rdata),
    .gpio_in       (gpio_in),
    .gpio_out      (gpio_out),
    .prog_we       (prog_we),
    .prog_addr     (prog_addr),
    .prog_data     (prog_data)
  );

  typedef struct {
    logic       w;
    logic [8:0] a;
    logic [7:0] d;
    logic [7:0] exp_rdata;
    logic [7:0] exp_gpio;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  // One complete transaction for core c; checks latency, strobe, data and one-shot
  task automatic do_txn(input int c, input logic w, input logic [8:0] a, input logic [7:0] d,
                        input logic [7:0] exp, input string name);
    int lat;
    bit got;
    @(posedge clk); #1;
    rwv[c] = w;
    addr[c*9 +: 9] = a;
    wd[c*8 +: 8] = d;
    req[c] = 1'b1;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 8) begin
      @(posedge clk); #1;
      lat++;
      if (gg != '0) got = 1'b1;
    end
    check({name, "_latency"}, lat, 2);
    check({name, "_grant"}, {30'd0, gg}, 32'(1 << c));
    check({name, "_rdata"}, {24'd0, rdata}, {24'd0, exp});
    @(posedge clk); #1;
    req[c] = 1'b0;
    check({name, "_oneshot"}, {30'd0, gg}, 32'd0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [N-1:0] seen;
    logic [N-1:0] drop;
    logic [N-1:0] exp_gg;

    reset = 1'b0; req = '0; rwv = '0; addr = '0; wd = '0;
    gpio_in = 8'h00; prog_we = 1'b0; prog_addr = 8'h00; prog_data = 8'h00;

    vecs[0]  = '{1'b0, 9'h010, 8'h00, 8'hA5, 8'h00};
    vecs[1]  = '{1'b1, 9'h020, 8'h3C, 8'h00, 8'h00};
    vecs[2]  = '{1'b0, 9'h020, 8'h00, 8'h3C, 8'h00};
    vecs[3]  = '{1'b1, 9'h100, 8'h5A, 8'h00, 8'h5A};
    vecs[4]  = '{1'b0, 9'h100, 8'h00, 8'h5A, 8'h5A};
    vecs[5]  = '{1'b0, 9'h101, 8'h00, 8'hC3, 8'h5A};
    vecs[6]  = '{1'b0, 9'h1FF, 8'h00, 8'h00, 8'h5A};
    vecs[7]  = '{1'b1, 9'h101, 8'hFF, 8'h00, 8'h5A};
    vecs[8]  = '{1'b1, 9'h1FF, 8'h11, 8'h00, 8'h5A};
    vecs[9]  = '{1'b1, 9'h0FF, 8'h99, 8'h00, 8'h5A};
    vecs[10] = '{1'b0, 9'h0FF, 8'h00, 8'h99, 8'h5A};
    vecs[11] = '{1'b0, 9'h010, 8'h00, 8'hA5, 8'h5A};

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("reset_grant", {30'd0, gg}, 32'd0);
    check("reset_rdata", {24'd0, rdata}, 32'd0);
    check("reset_gpio_out", {24'd0, gpio_out}, 32'd0);

    // Program load through the side port
    @(posedge clk); #1;
    prog_we = 1'b1; prog_addr = 8'h10; prog_data = 8'hA5;
    @(posedge clk); #1;
    prog_addr = 8'h30; prog_data = 8'h77;
    @(posedge clk); #1;
    prog_we = 1'b0;

    gpio_in = 8'hC3;
    repeat (3) @(posedge clk);

    for (int i = 0; i < 12; i++) begin
      do_txn(0, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].exp_rdata, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_gpio_out", i), {24'd0, gpio_out}, {24'd0, vecs[i].exp_gpio});
    end

    // Bus write and program write hit the same address on the same edge
    @(posedge clk); #1;
    rwv[0] = 1'b1; addr[8:0] = 9'h040; wd[7:0] = 8'h12; req[0] = 1'b1;
    @(posedge clk); #1;
    prog_we = 1'b1; prog_addr = 8'h40; prog_data = 8'h34;
    @(posedge clk); #1;
    prog_we = 1'b0;
    check("coll_grant", {30'd0, gg}, 32'd1);
    @(posedge clk); #1;
    req[0] = 1'b0;
    do_txn(0, 1'b0, 9'h040, 8'h00, 8'h12, "coll_read");

    // Core 1 drops its request during ACCESS: nothing may happen
    @(posedge clk); #1;
    rwv[1] = 1'b1; addr[17:9] = 9'h030; wd[15:8] = 8'hEE; req[1] = 1'b1;
    @(posedge clk); #1;
    req[1] = 1'b0;
    seen = '0;
    repeat (4) begin
      @(posedge clk); #1;
      seen |= gg;
    end
    check("abort_nogrant", {30'd0, seen}, 32'd0);
    do_txn(0, 1'b0, 9'h030, 8'h00, 8'h77, "abort_ram");

    // Reset asserted while in GRANT
    @(posedge clk); #1;
    rwv[0] = 1'b1; addr[8:0] = 9'h100; wd[7:0] = 8'hA7; req[0] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rstg_pre_grant", {30'd0, gg}, 32'd1);
    check("rstg_pre_gpio", {24'd0, gpio_out}, 32'hA7);
    #1 reset = 1'b0;
    #1;
    check("rstg_grant", {30'd0, gg}, 32'd0);
    check("rstg_gpio", {24'd0, gpio_out}, 32'd0);
    check("rstg_rdata", {24'd0, rdata}, 32'd0);
    req[0] = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    do_txn(0, 1'b0, 9'h010, 8'h00, 8'hA5, "post_reset");

    // Contention from reset: both cores keep re-requesting, grants must alternate
    pulse_reset();
    rwv = '0;
    addr[8:0] = 9'h010;
    addr[17:9] = 9'h020;
    drop = '0;
    for (int it = 0; it < 18; it++) begin
      @(posedge clk); #1;
      for (int c = 0; c < N; c++) begin
        if (drop[c]) begin
          req[c] = 1'b0;
          drop[c] = 1'b0;
        end else begin
          req[c] = 1'b1;
        end
      end
      exp_gg = '0;
      if (it >= 2 && ((it - 2) % 3) == 0) exp_gg = (((it - 2) / 3) % 2 == 1) ? 2'b10 : 2'b01;
      check($sformatf("rr_it%0d_grant", it), {30'd0, gg}, {30'd0, exp_gg});
      if (exp_gg != '0) begin
        check($sformatf("rr_it%0d_rdata", it), {24'd0, rdata}, exp_gg[0] ? 32'hA5 : 32'h3C);
      end
      for (int c = 0; c < N; c++) begin
        if (gg[c]) drop[c] = 1'b1;
      end
    end
    @(posedge clk); #1;
    req = '0;
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_bus_responder
`default_nettype wire

// File: doc/bus_responder.md
# bus_responder

Target end of the shared 9-bit CPU memory bus: arbitrates `grant_request` from up to `NUM_CORES` core initiators, serves each granted access from a 256-byte RAM or a small GPIO window, and returns a one-cycle `grant_given` with read data. Sits between the core instances and the top level. It is also the only path by which the program image reaches RAM, through a side-band load port.

## Interface
- `NUM_CORES`, default 2: number of bus initiators, range 1–4.
- `clk`  in  1  single system clock; all logic on posedge.
- `reset`  in  1  asynchronous, active-low.
- `grant_request`  in  NUM_CORES  per-core access request, level-held until granted.
- `rw`  in  NUM_CORES  per-core direction: 0 = read, 1 = write.
- `address`  in  NUM_CORES×9  per-core address; bit 8 = 1 selects GPIO, 0 selects RAM.
- `wdata`  in  NUM_CORES×8  per-core write data (core `data_out`).
- `grant_given`  out  NUM_CORES  one-hot, one-cycle completion strobe.
- `rdata`  out  8  read data (core `data_in`), shared by all cores.
- `gpio_in`  in  8  external input pins.
- `gpio_out`  out  8  external output register.
- `prog_we`  in  1  program-load write enable.
- `prog_addr`  in  8  program-load RAM address.
- `prog_data`  in  8  program-load data.

## Operation
- FSM states: IDLE, ACCESS, GRANT.
- IDLE:
  - If any request is high, select the winner round-robin, starting at `last+1` mod NUM_CORES.
  - Latch winner index, `rw`, `address` and `wdata`, then go to ACCESS.
  - If no request is high, stay in IDLE.
- ACCESS:
  - If the winner's request is still high: perform the access and go to GRANT.
  - If the winner's request has dropped: abort, with no write, no grant and no `last` update; return to IDLE.
- GRANT:
  - `grant_given[winner]` = 1 and `rdata` is valid.
  - Set `last` = winner, then go to IDLE.
- RAM access (address[8] = 0):
  - Read: `rdata` ← RAM[address[7:0]].
  - Write: RAM[address[7:0]] ← wdata; `rdata` ← 0x00.
- GPIO access (address[8] = 1):
  - Offset 0x00: read returns `gpio_out`; write loads `gpio_out`.
  - Offset 0x01: read returns `gpio_in`, synchronised through 2 flops; writes are ignored.
  - Any other offset: reads return 0x00; writes are ignored.
- `rdata` holds its last value outside GRANT.
- Program-load port:
  - `prog_we` writes RAM[prog_addr] on any cycle.
  - If a bus RAM write to the same address commits in the same cycle, the bus write wins.
- Reset values: state IDLE, `grant_given` 0, `rdata` 0x00, `gpio_out` 0x00, `last` = NUM_CORES−1 (so core 0 wins first).
- RAM contents are not reset.
- Reset asserted mid-transaction returns the FSM to IDLE immediately. A pending write is not committed unless its edge already occurred.

## Timing
- Cycle-level sequence:
  - Cycle n: request visible in IDLE.
  - Cycle n+1: ACCESS.
  - Cycle n+2: GRANT.
  - Edge ending n+1: RAM and GPIO read and write commit.
- Latency from request sampled to `grant_given` high is 2 cycles.
- Throughput is at most one transaction per 3 cycles.
- `grant_given` is high for exactly one cycle. The core drops its request at the edge ending GRANT.
- The requester must not be re-granted on stale `grant_request`: IDLE samples requests in the cycle after GRANT, when the core has already dropped its request.
- Requests and `address` may change only while `grant_given` for that core is 0. The block samples them only in IDLE and ACCESS.
- Simultaneous requests are granted strictly round-robin; no core waits more than NUM_CORES transactions.

## Structure
- Package `bus_pkg` holds:
  - state enum `bus_state_t` {IDLE, ACCESS, GRANT};
  - `RW_READ` = 0 and `RW_WRITE` = 1;
  - `GPIO_OUT_OFS` = 8'h00 and `GPIO_IN_OFS` = 8'h01;
  - `RAM_DEPTH` = 256.
- Sub-module `bus_ram`: 256×8 RAM with synchronous read and write, plus a second write-only port for program load, with bus-port priority on collision.
- The top level contains the arbiter, FSM, GPIO registers and synchroniser.

## Test plan
- Program load then read: `prog_we` writes 0xA5 to 0x10; core 0 reads 0x010 → `grant_given[0]` 2 cycles after request, `rdata` = 0xA5.
- RAM write then read: core 0 writes 0x3C to 0x020, then reads 0x020 → `rdata` = 0x3C; the write cycle returns `rdata` = 0x00.
- GPIO:
  - Write 0x5A to 0x100 → `gpio_out` = 0x5A.
  - Drive `gpio_in` = 0xC3, wait 3 cycles, read 0x101 → 0xC3.
  - Read 0x1FF → 0x00.
- Contention: both cores request in the same cycle from reset → core 0 granted first, core 1 granted exactly 3 cycles later; repeat and verify alternation.
- Abort and reset:
  - Core 1 drops its request during ACCESS → no grant, RAM unchanged.
  - Assert reset during GRANT → `grant_given` = 0 and `gpio_out` = 0x00 immediately; FSM resumes in IDLE.
